// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern,
// hex-to-gfedcba active-low table and the digit-index width helper.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0..15 -> gfedcba pattern, 0 = segment lit
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int digit_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational nibble to gfedcba active-low segment decoder.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed N-digit common-anode display driver with double-buffered
// data, guard cycles between digits, leading-zero blanking and PWM dimming.
module sseg_mux_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   hex_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  input  logic                    lzb_en,
  input  logic [3:0]              duty,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int DIG_W  = digit_idx_width(N_DIGITS);
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] GUARD_SLOT = SLOT_W'(GUARD);
  localparam logic [DIG_W-1:0]  LAST_DIG   = DIG_W'(N_DIGITS - 1);

  logic [SLOT_W-1:0]     r_slot_cnt;
  logic [DIG_W-1:0]      r_digit_idx;
  logic [3:0]            r_pwm_cnt;
  logic [4*N_DIGITS-1:0] r_act_hex, r_pend_hex;
  logic [N_DIGITS-1:0]   r_act_dp, r_pend_dp;
  logic [N_DIGITS-1:0]   r_act_blank, r_pend_blank;
  logic                  r_pend_valid;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_sseg;
  logic                  r_dp;
  logic                  r_frame_tick;

  logic                  w_slot_wrap;
  logic                  w_frame_end;
  logic [3:0]            w_hex_arr [N_DIGITS];
  logic [N_DIGITS-1:0]   w_zero_from;
  logic                  w_all_zero;
  logic [N_DIGITS-1:0]   w_an_sel;
  logic [3:0]            w_cur_hex;
  logic [6:0]            w_dec_seg;
  logic                  w_suppress;
  logic                  w_pwm_on;
  logic                  w_dark;

  assign w_slot_wrap = (r_slot_cnt == LAST_SLOT);
  assign w_frame_end = w_slot_wrap && (r_digit_idx == LAST_DIG);

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign w_hex_arr[gi] = r_act_hex[4*gi +: 4];
      assign w_an_sel[gi]  = (r_digit_idx != DIG_W'(gi));
    end
  endgenerate

  // w_zero_from[k] is set when digit k and every digit above it are zero
  always_comb begin
    w_zero_from = '0;
    w_all_zero  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_all_zero     = w_all_zero & (w_hex_arr[i] == 4'd0);
      w_zero_from[i] = w_all_zero;
    end
  end

  assign w_cur_hex  = w_hex_arr[r_digit_idx];
  assign w_suppress = lzb_en && (r_digit_idx != '0) && w_zero_from[r_digit_idx];
  assign w_pwm_on   = (r_pwm_cnt <= duty);
  assign w_dark     = (r_slot_cnt < GUARD_SLOT) || !w_pwm_on || r_act_blank[r_digit_idx];

  sseg_decode u_decode (
    .i_nibble (w_cur_hex),
    .o_seg    (w_dec_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_pwm_cnt   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      if (w_slot_wrap) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == LAST_DIG) ? '0 : r_digit_idx + DIG_W'(1);
      end else begin
        r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
      end
    end
  end

  // A load coinciding with a frame end still commits the older pending data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_hex    <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
      r_pend_hex   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_frame_end && r_pend_valid) begin
        r_act_hex   <= r_pend_hex;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
      end
      if (load) begin
        r_pend_hex   <= hex_in;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
        r_pend_valid <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an         <= '1;
      r_sseg       <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_dark) begin
        r_an   <= '1;
        r_sseg <= SEG_BLANK;
        r_dp   <= 1'b1;
      end else begin
        r_an   <= w_an_sel;
        r_sseg <= w_suppress ? SEG_BLANK : w_dec_seg;
        r_dp   <= ~r_act_dp[r_digit_idx];
      end
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver with 4 digits, 4-cycle slots, 1 guard cycle.
module tb_sseg_mux_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lzb_en = 1'b0;
  logic [3:0]  duty = 4'hF;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] cap_an   [16];
  logic [6:0] cap_sseg [16];
  logic       cap_dp   [16];

  sseg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lzb_en     (lzb_en),
    .duty       (duty),
    .an         (an),
    .sseg       (sseg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // At most one anode may be active in any cycle
  always @(negedge clk) begin
    n_cmp++;
    if ($countones(~an) > 1) begin
      n_err++;
      $display("FAIL one_hot_an: an=%b required at most one low bit", an);
    end
  end

  task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    hex_in   = h;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load hex=%h dp=%b blank=%b", h, d, b);
  endtask

  // Advance to the next frame_tick sample; lit counts samples with any anode on
  task automatic wait_tick(output int lit);
    bit found;
    lit = 0;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an != 4'hF) lit++;
      if (frame_tick) found = 1;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: frame_tick=0 after 64 cycles, required 1");
    end
  endtask

  task automatic sample_frame();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap_an[i]   = an;
      cap_sseg[i] = sseg;
      cap_dp[i]   = dp;
    end
  endtask

  task automatic test_reset();
    int lit, t1, t2, nt;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL rst_an: got %h required F", an); end
    n_cmp++; if (sseg !== 7'h7F) begin n_err++; $display("FAIL rst_sseg: got %h required 7F", sseg); end
    n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL rst_dp: got %b required 1", dp); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b required 0", frame_tick); end
    reset_n = 1'b1;
    lit = 0; t1 = 0; t2 = 0; nt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (an != 4'hF || sseg != 7'h7F || dp != 1'b1) lit++;
      if (frame_tick) begin
        nt++;
        if (t1 == 0) t1 = k; else if (t2 == 0) t2 = k;
      end
    end
    n_cmp++; if (lit != 0) begin n_err++; $display("FAIL rst_dark: %0d lit cycles, required 0", lit); end
    n_cmp++; if (t1 != 16) begin n_err++; $display("FAIL rst_tick1: at cycle %0d required 16", t1); end
    n_cmp++; if (t2 != 32) begin n_err++; $display("FAIL rst_tick2: at cycle %0d required 32", t2); end
    n_cmp++; if (nt != 2) begin n_err++; $display("FAIL rst_tick_cnt: %0d ticks required 2", nt); end
    $display("test_reset done: first ticks at %0d and %0d", t1, t2);
  endtask

  task automatic test_load_display();
    int lit;
    wait_tick(lit);
    do_load(16'h1234, 4'b0100, 4'b0000);
    wait_tick(lit);
    n_cmp++; if (lit != 0) begin n_err++; $display("FAIL pre_commit_dark: %0d lit, required 0", lit); end
    sample_frame();
    n_cmp++; if (cap_an[0] !== 4'hF) begin n_err++; $display("FAIL guard0_an: got %b required 1111", cap_an[0]); end
    n_cmp++; if (cap_an[1] !== 4'b1110 || cap_sseg[1] !== 7'h19 || cap_dp[1] !== 1'b1) begin
      n_err++; $display("FAIL dig0: an=%b sseg=%h dp=%b required 1110 19 1", cap_an[1], cap_sseg[1], cap_dp[1]); end
    n_cmp++; if (cap_an[4] !== 4'hF) begin n_err++; $display("FAIL guard1_an: got %b required 1111", cap_an[4]); end
    n_cmp++; if (cap_an[5] !== 4'b1101 || cap_sseg[5] !== 7'h30 || cap_dp[5] !== 1'b1) begin
      n_err++; $display("FAIL dig1: an=%b sseg=%h dp=%b required 1101 30 1", cap_an[5], cap_sseg[5], cap_dp[5]); end
    n_cmp++; if (cap_an[9] !== 4'b1011 || cap_sseg[9] !== 7'h24 || cap_dp[9] !== 1'b0) begin
      n_err++; $display("FAIL dig2: an=%b sseg=%h dp=%b required 1011 24 0", cap_an[9], cap_sseg[9], cap_dp[9]); end
    n_cmp++; if (cap_an[15] !== 4'b0111 || cap_sseg[15] !== 7'h79 || cap_dp[15] !== 1'b1) begin
      n_err++; $display("FAIL dig3: an=%b sseg=%h dp=%b required 0111 79 1", cap_an[15], cap_sseg[15], cap_dp[15]); end
    $display("test_load_display done");
  endtask

  task automatic test_last_wins();
    int lit;
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    do_load(16'h5555, 4'b0000, 4'b0000);
    wait_tick(lit);
    sample_frame();
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (cap_sseg[4*d+2] !== 7'h12) begin
        n_err++; $display("FAIL last_wins_dig%0d: sseg=%h required 12", d, cap_sseg[4*d+2]);
      end
    end
    $display("test_last_wins done");
  endtask

  task automatic test_coincident_load();
    repeat (15) @(negedge clk);
    do_load(16'h8888, 4'b0000, 4'b0100);
    n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL coinc_tick: got %b required 1", frame_tick); end
    sample_frame();
    n_cmp++; if (cap_sseg[5] !== 7'h12) begin n_err++; $display("FAIL coinc_old_frame: sseg=%h required 12", cap_sseg[5]); end
    sample_frame();
    n_cmp++; if (cap_sseg[5] !== 7'h00 || cap_an[5] !== 4'b1101) begin
      n_err++; $display("FAIL coinc_new_frame: an=%b sseg=%h required 1101 00", cap_an[5], cap_sseg[5]); end
    n_cmp++; if (cap_an[9] !== 4'hF || cap_sseg[9] !== 7'h7F) begin
      n_err++; $display("FAIL blank_dig2: an=%b sseg=%h required 1111 7F", cap_an[9], cap_sseg[9]); end
    $display("test_coincident_load done");
  endtask

  task automatic test_lzb();
    int lit;
    lzb_en = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b0000);
    wait_tick(lit);
    sample_frame();
    n_cmp++; if (cap_an[1] !== 4'b1110 || cap_sseg[1] !== 7'h40) begin
      n_err++; $display("FAIL lzb_dig0: an=%b sseg=%h required 1110 40", cap_an[1], cap_sseg[1]); end
    n_cmp++; if (cap_sseg[5] !== 7'h78) begin n_err++; $display("FAIL lzb_dig1: sseg=%h required 78", cap_sseg[5]); end
    n_cmp++; if (cap_sseg[9] !== 7'h7F) begin n_err++; $display("FAIL lzb_dig2: sseg=%h required 7F", cap_sseg[9]); end
    n_cmp++; if (cap_sseg[13] !== 7'h7F) begin n_err++; $display("FAIL lzb_dig3: sseg=%h required 7F", cap_sseg[13]); end
    do_load(16'h0000, 4'b1000, 4'b0000);
    wait_tick(lit);
    sample_frame();
    n_cmp++; if (cap_sseg[1] !== 7'h40) begin n_err++; $display("FAIL lzb0_dig0: sseg=%h required 40", cap_sseg[1]); end
    n_cmp++; if (cap_sseg[5] !== 7'h7F) begin n_err++; $display("FAIL lzb0_dig1: sseg=%h required 7F", cap_sseg[5]); end
    n_cmp++; if (cap_an[13] !== 4'b0111 || cap_sseg[13] !== 7'h7F || cap_dp[13] !== 1'b0) begin
      n_err++; $display("FAIL lzb0_dig3_dp: an=%b sseg=%h dp=%b required 0111 7F 0", cap_an[13], cap_sseg[13], cap_dp[13]); end
    lzb_en = 1'b0;
    sample_frame();
    n_cmp++; if (cap_sseg[13] !== 7'h40) begin n_err++; $display("FAIL lzb_off_dig3: sseg=%h required 40", cap_sseg[13]); end
    $display("test_lzb done");
  endtask

  task automatic test_pwm();
    int lit, guard_lit, tmp;
    duty = 4'd3;
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_tick(tmp);
    lit = 0; guard_lit = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (an != 4'hF) begin
        if (i % 4 == 0) guard_lit++; else lit++;
      end
    end
    n_cmp++; if (lit < 47 || lit > 49) begin n_err++; $display("FAIL pwm_lit: %0d of 192 required 48+-1", lit); end
    n_cmp++; if (guard_lit != 0) begin n_err++; $display("FAIL pwm_guard: %0d lit guard cycles required 0", guard_lit); end
    duty = 4'hF;
    $display("test_pwm done: lit=%0d of 192", lit);
  endtask

  task automatic test_reset_mid();
    int lit, nt;
    wait_tick(lit);
    do_load(16'h8888, 4'b0000, 4'b0000);
    repeat (9) @(negedge clk);
    n_cmp++; if (an !== 4'b1011 || sseg !== 7'h24) begin
      n_err++; $display("FAIL mid_pre: an=%b sseg=%h required 1011 24", an, sseg); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (an !== 4'hF || sseg !== 7'h7F || dp !== 1'b1) begin
      n_err++; $display("FAIL mid_async: an=%b sseg=%h dp=%b required 1111 7F 1", an, sseg, dp); end
    @(negedge clk);
    reset_n = 1'b1;
    lit = 0; nt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (an != 4'hF) lit++;
      if (frame_tick) nt++;
    end
    n_cmp++; if (lit != 0) begin n_err++; $display("FAIL mid_dark: %0d lit required 0", lit); end
    n_cmp++; if (nt != 2) begin n_err++; $display("FAIL mid_ticks: %0d required 2", nt); end
    do_load(16'h4321, 4'b0000, 4'b0000);
    wait_tick(lit);
    sample_frame();
    n_cmp++; if (cap_an[1] !== 4'b1110 || cap_sseg[1] !== 7'h79) begin
      n_err++; $display("FAIL mid_new_dig0: an=%b sseg=%h required 1110 79", cap_an[1], cap_sseg[1]); end
    n_cmp++; if (cap_sseg[13] !== 7'h19) begin n_err++; $display("FAIL mid_new_dig3: sseg=%h required 19", cap_sseg[13]); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_load_display();
    test_last_wins();
    test_coincident_load();
    test_lzb();
    test_pwm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
